// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe. The producer drives the input side and
// the consumer drives out_ready.
interface imm_gen_pipe_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      InstD;
    logic [2:0]       ImmSrcD;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  ImmExtE;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    // Environment side: feeds instructions, consumes immediates.
    modport master (
        output in_valid, InstD, ImmSrcD, in_tag, out_ready,
        input  in_ready, out_valid, ImmExtE, out_tag, out_illegal
    );

    // Block side.
    modport slave (
        input  in_valid, InstD, ImmSrcD, in_tag, out_ready,
        output in_ready, out_valid, ImmExtE, out_tag, out_illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator behind a two-entry valid/ready skid
// buffer. in_ready depends only on registered state, so the consumer's
// out_ready never reaches the producer combinationally.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) (
    input logic          clk,
    input logic          rst,
    input logic          flush,
    imm_gen_pipe_if.slave bus
);
    // Encoding is {main valid, skid valid}; {0,1} cannot occur.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b10,
        StFull  = 2'b11
    } state_e;

    state_e state_q, state_d;

    logic [XLEN-1:0]  main_imm_q, skid_imm_q;
    logic [TAG_W-1:0] main_tag_q, skid_tag_q;
    logic             main_ill_q, skid_ill_q;

    logic [XLEN-1:0] imm_dec;
    logic            ill_dec;
    logic [31:0]     inst;
    logic            sgn;
    logic            in_xfer, out_xfer;
    logic            load_main_in, load_main_skid, load_skid;
    logic            unused_opcode;

    assign inst          = bus.InstD;
    assign sgn           = inst[31];
    assign unused_opcode = ^inst[6:0];

    assign bus.in_ready    = ~state_q[0];
    assign bus.out_valid   = state_q[1];
    assign bus.ImmExtE     = main_imm_q;
    assign bus.out_tag     = main_tag_q;
    assign bus.out_illegal = main_ill_q;

    assign in_xfer  = bus.in_valid & ~state_q[0];
    assign out_xfer = state_q[1] & bus.out_ready;

    // Immediate extraction and extension for the selected format.
    always_comb begin
        imm_dec = '0;
        ill_dec = 1'b0;
        case (bus.ImmSrcD)
            3'b000: imm_dec = {{(XLEN-12){sgn}}, inst[31:20]};
            3'b001: imm_dec = {{(XLEN-12){sgn}}, inst[31:25], inst[11:7]};
            3'b010: imm_dec = {{(XLEN-12){sgn}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            3'b011: imm_dec = {{(XLEN-20){sgn}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            // Sign-extend the 20-bit field first, then shift it into place.
            3'b100: imm_dec = {{(XLEN-20){sgn}}, inst[31:12]} << 12;
            3'b101: imm_dec = {{(XLEN-5){1'b0}}, inst[19:15]};
            3'b110: imm_dec = {{(XLEN-6){1'b0}}, (XLEN == 64) ? inst[25] : 1'b0, inst[24:20]};
            default: ill_dec = 1'b1;
        endcase
    end

    // Occupancy transitions and load enables; flush overrides every transfer.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_xfer) begin
                        state_d      = StOne;
                        load_main_in = 1'b1;
                    end
                end
                StOne: begin
                    if (in_xfer && out_xfer) begin
                        load_main_in = 1'b1;
                    end else if (in_xfer) begin
                        state_d   = StFull;
                        load_skid = 1'b1;
                    end else if (out_xfer) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (out_xfer) begin
                        state_d        = StOne;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload registers; main only changes when it is loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_imm_q <= '0;
            main_tag_q <= '0;
            main_ill_q <= 1'b0;
            skid_imm_q <= '0;
            skid_tag_q <= '0;
            skid_ill_q <= 1'b0;
        end else begin
            if (load_main_in) begin
                main_imm_q <= imm_dec;
                main_tag_q <= bus.in_tag;
                main_ill_q <= ill_dec;
            end else if (load_main_skid) begin
                main_imm_q <= skid_imm_q;
                main_tag_q <= skid_tag_q;
                main_ill_q <= skid_ill_q;
            end
            if (load_skid) begin
                skid_imm_q <= imm_dec;
                skid_tag_q <= bus.in_tag;
                skid_ill_q <= ill_dec;
            end
        end
    end
endmodule
